// File: rtl/fe_pkg.sv
// Shared types and constants for the RV32I instruction fetch front end.
package fe_pkg;

  typedef logic [31:0] RV32I_PC_t;
  typedef logic [31:0] RV32I_OPERAND_t;

  typedef struct packed {
    RV32I_PC_t      pc;
    RV32I_OPERAND_t word;
  } fetch_entry_t;

  localparam RV32I_OPERAND_t RV32I_NOP = 32'h0000_0013;
  localparam RV32I_PC_t      PC_STEP   = 32'd4;

endpackage

// File: rtl/rv32i_fetch_fifo.sv
// Small synchronous FIFO of {pc, word} entries; flush beats push and pop.
module rv32i_fetch_fifo
  import fe_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  fetch_entry_t  i_data,
  output fetch_entry_t  o_head,
  output logic [CW-1:0] o_count
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_wr_en;

  assign w_wr_en = i_push && !i_flush && !rst;
  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop)  r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  // The fetch credit scheme must never let a response land in a full buffer.
  always_ff @(posedge clk) begin
    if (!rst && !i_flush)
      assert (!(i_push && !i_pop && r_count == CW'(DEPTH)));
  end

endmodule

// File: rtl/rv32i_fetch_unit.sv
// RV32I fetch front end: PC, credit-limited imem requests, response buffer, redirect flush.
// Optional RV32I_FETCH_MISALIGN_TRAP_EN: misaligned redirect raises sticky fetch_fault.
module rv32i_fetch_unit
  import fe_pkg::*;
#(
  parameter RV32I_PC_t RESET_PC   = 32'h0000_0000,
  parameter int        FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  output logic           imem_req_valid,
  output RV32I_PC_t      imem_req_addr,
  input  logic           imem_req_ready,
  input  logic           imem_rsp_valid,
  input  RV32I_OPERAND_t imem_rsp_data,
  input  logic           redirect_valid,
  input  RV32I_PC_t      redirect_pc,
  output logic           instr_valid,
  output RV32I_OPERAND_t instr,
  output RV32I_PC_t      instr_pc,
  input  logic           instr_ready,
  output logic           fetch_fault
);

  localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_W = FIFO_DEPTH[CW:0];

  logic          r_rst_q;
  RV32I_PC_t     r_fetch_pc;
  RV32I_PC_t     r_rsp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;

  logic          w_req_hs;
  logic          w_push;
  logic          w_pop;
  logic          w_fault;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_out_nxt;
  logic [CW:0]   w_inflight;
  RV32I_PC_t     w_redir_pc;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_data;

`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
  logic r_fault;

  always_ff @(posedge clk) begin
    if (rst)                 r_fault <= 1'b0;
    else if (redirect_valid) r_fault <= |redirect_pc[1:0];
  end

  assign w_fault = r_fault;
`else
  assign w_fault = 1'b0;
`endif

  assign w_redir_pc     = redirect_pc & ~32'd3;
  assign w_inflight     = {1'b0, r_outstanding} + {1'b0, w_count};
  assign imem_req_valid = !r_rst_q && !w_fault && (w_inflight < DEPTH_W);
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_hs       = imem_req_valid && imem_req_ready;
  assign w_out_nxt      = r_outstanding + CW'(w_req_hs) - CW'(imem_rsp_valid);

  // A response arriving with a redirect is stale by definition, so it is never pushed.
  assign w_push      = imem_rsp_valid && (r_discard == '0) && !redirect_valid;
  assign w_push_data = '{pc: r_rsp_pc, word: imem_rsp_data};
  assign w_pop       = instr_valid && instr_ready;

  assign instr_valid = (w_count != '0);
  assign instr       = instr_valid ? w_head.word : (r_rst_q ? '0 : RV32I_NOP);
  assign instr_pc    = instr_valid ? w_head.pc : '0;
  assign fetch_fault = w_fault;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rst_q       <= 1'b1;
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_rst_q       <= 1'b0;
      r_outstanding <= w_out_nxt;
      if (redirect_valid) begin
        // Everything still in flight after this cycle belongs to the old stream.
        r_fetch_pc <= w_redir_pc;
        r_rsp_pc   <= w_redir_pc;
        r_discard  <= w_out_nxt;
      end else begin
        if (w_req_hs) r_fetch_pc <= r_fetch_pc + PC_STEP;
        if (imem_rsp_valid) begin
          if (r_discard != '0) r_discard <= r_discard - 1'b1;
          else                 r_rsp_pc  <= r_rsp_pc + PC_STEP;
        end
      end
    end
  end

  rv32i_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_data  (w_push_data),
    .o_head  (w_head),
    .o_count (w_count)
  );

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Scoreboard bench for rv32i_fetch_unit with a latency-programmable in-order memory model.
module tb_rv32i_fetch_unit;
  import fe_pkg::*;

  localparam RV32I_PC_t RESET_PC = 32'h0000_0000;
  localparam int        DEPTH    = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           imem_req_valid;
  RV32I_PC_t      imem_req_addr;
  logic           imem_req_ready;
  logic           imem_rsp_valid;
  RV32I_OPERAND_t imem_rsp_data;
  logic           redirect_valid;
  RV32I_PC_t      redirect_pc;
  logic           instr_valid;
  RV32I_OPERAND_t instr;
  RV32I_PC_t      instr_pc;
  logic           instr_ready;
  logic           fetch_fault;

  always #5 clk = ~clk;

  rv32i_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .fetch_fault    (fetch_fault)
  );

  typedef struct {
    int        due;
    RV32I_PC_t addr;
  } mrsp_t;

  mrsp_t        mem_q [$];
  fetch_entry_t sb    [$];
  int           n_chk = 0;
  int           n_pass = 0;
  int           cyc = 0;
  int           lat = 1;
  int           n_req = 0;
  int           n_pop = 0;
  int           mark;
  RV32I_PC_t    exp_fetch = RESET_PC;

  function automatic logic [31:0] mdata(RV32I_PC_t a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic samp;
    @(negedge clk); #1;
  endtask

  // In-order memory: a request handshaken in cycle k answers in cycle k+lat.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      if (mem_q.size() != 0 && mem_q[0].due == cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mdata(mem_q[0].addr);
        void'(mem_q.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
      end
    end
  end

  // Scoreboard: each issued fetch queues its expected {pc, word}; a redirect kills the queue.
  initial begin
    fetch_entry_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        mem_q.delete();
        sb.delete();
        exp_fetch = RESET_PC;
        n_req     = 0;
        n_pop     = 0;
      end else begin
        if (instr_valid && instr_ready) begin
          n_pop++;
          if (sb.size() == 0) begin
            chk("unexpected_pop", 32'(instr_valid), 32'd0);
          end else begin
            e = sb.pop_front();
            chk("instr_pc", instr_pc, e.pc);
            chk("instr", instr, e.word);
          end
        end
        if (imem_req_valid && imem_req_ready) begin
          n_req++;
          chk("req_addr", imem_req_addr, exp_fetch);
          mem_q.push_back('{cyc + lat, imem_req_addr});
          sb.push_back('{pc: exp_fetch, word: mdata(exp_fetch)});
          exp_fetch = exp_fetch + 32'd4;
        end
        if (redirect_valid) begin
          sb.delete();
          exp_fetch = redirect_pc & ~32'd3;
        end
      end
    end
  end

  task automatic do_reset(int l);
    tick;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    lat            = l;
    repeat (2) tick;
    samp;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    tick;
    rst = 1'b0;
  endtask

  task automatic wait_valid(int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (instr_valid) break;
      tick;
      samp;
    end
    chk("wait_valid", 32'(instr_valid), 32'd1);
  endtask

  task automatic redirect(RV32I_PC_t pc);
    tick;
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick;
    redirect_valid = 1'b0;
    samp;
  endtask

  initial begin
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Cold start with 1-cycle memory: first instruction in cycle 3, then one per cycle.
    do_reset(1);
    samp; chk("c0_req_valid", 32'(imem_req_valid), 32'd0);
    tick; samp; chk("c1_req_valid", 32'(imem_req_valid), 32'd1);
    chk("c1_req_addr", imem_req_addr, RESET_PC);
    tick; samp; chk("c2_instr_valid", 32'(instr_valid), 32'd0);
    tick; samp; chk("c3_instr_valid", 32'(instr_valid), 32'd1);
    chk("c3_instr_pc", instr_pc, RESET_PC);
    mark = n_pop;
    repeat (16) begin tick; samp; end
    chk("throughput", 32'(n_pop - mark), 32'd16);

    // Stalled consumer: credit stops at DEPTH requests, then drains in order.
    instr_ready = 1'b0;
    do_reset(1);
    samp;
    repeat (12) begin tick; samp; end
    chk("credit_reqs", 32'(n_req), 32'(DEPTH));
    chk("credit_req_valid", 32'(imem_req_valid), 32'd0);
    chk("full_instr_valid", 32'(instr_valid), 32'd1);
    tick; instr_ready = 1'b1;
    samp; chk("drain_first_pc", instr_pc, 32'd0);
    repeat (5) begin tick; samp; end
    chk("drain_pops", 32'(n_pop), 32'd6);

    // 3-cycle memory, redirect with responses in flight.
    do_reset(3);
    samp;
    repeat (10) begin tick; samp; end
    redirect(32'h0000_0100);
    chk("r3_n1_valid", 32'(instr_valid), 32'd0);
    chk("r3_n1_addr", imem_req_addr, 32'h0000_0100);
    tick; samp;
    wait_valid(12);
    chk("r3_first_pc", instr_pc, 32'h0000_0100);

    // Redirect coincident with a request handshake and a response.
    do_reset(1);
    samp;
    repeat (8) begin tick; samp; end
    tick;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    samp;
    chk("coinc_hs", 32'(imem_req_valid && imem_req_ready), 32'd1);
    chk("coinc_rsp", 32'(imem_rsp_valid), 32'd1);
    tick; redirect_valid = 1'b0;
    samp; chk("coinc_n1_valid", 32'(instr_valid), 32'd0);
    chk("coinc_n1_addr", imem_req_addr, 32'h0000_0040);
    tick; samp; chk("coinc_n2_valid", 32'(instr_valid), 32'd0);
    tick; samp; chk("coinc_n3_valid", 32'(instr_valid), 32'd1);
    chk("coinc_n3_pc", instr_pc, 32'h0000_0040);

    // Address wrap at the top of the space.
    redirect(32'hFFFF_FFF8);
    wait_valid(8);
    chk("wrap_pc0", instr_pc, 32'hFFFF_FFF8);
    tick; samp; chk("wrap_pc1", instr_pc, 32'hFFFF_FFFC);
    tick; samp; chk("wrap_pc2", instr_pc, 32'h0000_0000);

    // Misaligned redirect.
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
    redirect(32'h0000_0102);
    chk("fault_set", 32'(fetch_fault), 32'd1);
    chk("fault_flush", 32'(instr_valid), 32'd0);
    mark = n_req;
    repeat (5) begin tick; samp; end
    chk("fault_no_req", 32'(n_req - mark), 32'd0);
    chk("fault_req_valid", 32'(imem_req_valid), 32'd0);
    redirect(32'h0000_0200);
    chk("fault_clear", 32'(fetch_fault), 32'd0);
    wait_valid(8);
    chk("fault_resume_pc", instr_pc, 32'h0000_0200);
`else
    redirect(32'h0000_0102);
    chk("misalign_fault", 32'(fetch_fault), 32'd0);
    wait_valid(8);
    chk("misalign_pc", instr_pc, 32'h0000_0100);
`endif

    repeat (4) begin tick; samp; end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
